// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: a byte accepted through a valid/ready handshake is serialised LSB first.
// A one-entry holding register lets the next byte queue up behind a running frame, so frames can run back to back.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_active,
  output logic       completeBit
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic [7:0]    hold_reg;
  logic          hold_full;

  logic accept;
  logic bit_done;
  logic stop_done;
  logic hold_load;

  assign accept    = tx_valid && tx_ready;
  assign bit_done  = (bit_cnt == CNT_LAST);
  assign stop_done = (state == STOP) && bit_done;
  // On the final STOP cycle an accepted byte goes straight to the shifter instead of the holding register.
  assign hold_load = accept && (state != IDLE) && !stop_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      hold_reg    <= '0;
      hold_full   <= 1'b0;
      tx_serial   <= 1'b1;
      tx_active   <= 1'b0;
      tx_ready    <= 1'b1;
      completeBit <= 1'b0;
    end else begin
      completeBit <= stop_done;
      // Falls in the accept cycle, but rises only one cycle after the holding register drains.
      tx_ready    <= !(hold_full || hold_load);

      if (hold_load) begin
        hold_reg  <= tx_byte;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          bit_cnt   <= '0;
          bit_idx   <= '0;
          tx_serial <= 1'b1;
          tx_active <= 1'b0;
          if (accept) begin
            shift_reg <= tx_byte;
            state     <= START;
            tx_serial <= 1'b0;
            tx_active <= 1'b1;
          end
        end

        START: begin
          if (bit_done) begin
            bit_cnt   <= '0;
            state     <= DATA;
            tx_serial <= shift_reg[0];
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx   <= '0;
              state     <= STOP;
              tx_serial <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= shift_reg >> 1;
              tx_serial <= shift_reg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (hold_full) begin
              shift_reg <= hold_reg;
              hold_full <= 1'b0;
              state     <= START;
              tx_serial <= 1'b0;
            end else if (accept) begin
              shift_reg <= tx_byte;
              state     <= START;
              tx_serial <= 1'b0;
            end else begin
              state     <= IDLE;
              tx_serial <= 1'b1;
              tx_active <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          tx_serial <= 1'b1;
          tx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: cycle-level frame timeline model at CLKS_PER_BIT=4, plus a default-baud timing run.
module tb_uart_transmitter;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, tx_valid, tx_ready, tx_serial, tx_active, completeBit;
  logic [7:0] tx_byte;

  logic       reset_s, tx_valid_s, tx_ready_s, tx_serial_s, tx_active_s, complete_s;
  logic [7:0] tx_byte_s;

  uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_byte(tx_byte),
    .tx_ready(tx_ready), .tx_serial(tx_serial), .tx_active(tx_active), .completeBit(completeBit)
  );

  uart_transmitter dut_slow (
    .clk(clk), .reset(reset_s), .tx_valid(tx_valid_s), .tx_byte(tx_byte_s),
    .tx_ready(tx_ready_s), .tx_serial(tx_serial_s), .tx_active(tx_active_s), .completeBit(complete_s)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model: the frame on the line is described by its start cycle and its 10 line bits.
  bit         f_on;
  int         f_start;
  logic [9:0] f_bits;
  bit         hold_v;
  logic [7:0] hold_b;
  bit         ready_e;
  bit         comp_e;
  int         comp_seen;

  function automatic logic exp_serial();
    if (!f_on) return 1'b1;
    return f_bits[(cyc - f_start) / CPB];
  endfunction

  task automatic start_frame(input logic [7:0] b);
    f_on    = 1'b1;
    f_start = cyc + 1;
    f_bits  = {1'b1, b, 1'b0};
  endtask

  task automatic model_reset();
    f_on = 1'b0; hold_v = 1'b0; ready_e = 1'b1; comp_e = 1'b0;
  endtask

  task automatic model_update(input logic v, input logic [7:0] b, input logic r);
    bit acc, last, nready;
    acc    = v && ready_e && !r;
    last   = f_on && (cyc - f_start == FRAME - 1);
    nready = !(hold_v || (acc && f_on && !last));
    if (r) begin
      model_reset();
      return;
    end
    comp_e = last;
    if (f_on && !last) begin
      if (acc) begin
        hold_v = 1'b1;
        hold_b = b;
      end
    end else if (last) begin
      if (hold_v) begin
        start_frame(hold_b);
        hold_v = 1'b0;
      end else if (acc) start_frame(b);
      else f_on = 1'b0;
    end else if (acc) begin
      start_frame(b);
    end
    ready_e = nready;
  endtask

  // Called just after a falling edge: check this cycle's outputs, then drive inputs for the coming edge.
  task automatic tick(input logic v, input logic [7:0] b, input logic r);
    check_eq("tx_serial", tx_serial, exp_serial());
    check_eq("tx_active", tx_active, f_on);
    check_eq("tx_ready", tx_ready, ready_e);
    check_eq("completeBit", completeBit, comp_e);
    if (completeBit === 1'b1) comp_seen++;
    tx_valid = v;
    tx_byte  = b;
    reset    = r;
    model_update(v, b, r);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom), 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int first_low, last_low, low_cnt, comp_n, comp_cnt;

    reset = 1'b1; tx_valid = 1'b0; tx_byte = 8'h00;
    reset_s = 1'b1; tx_valid_s = 1'b0; tx_byte_s = 8'h00;
    comp_seen = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();

    // reset state, held with tx_valid high to show it is ignored under reset
    tick(1'b1, 8'hEE, 1'b1);
    idle(3);

    // single byte from idle
    base = comp_seen;
    cyc  = 0;
    tick(1'b1, 8'hA5, 1'b0);
    idle(45);
    check_eq("single_frames", comp_seen - base, 1);

    // back-to-back plus an overflow offer that must be ignored
    base = comp_seen;
    cyc  = 0;
    tick(1'b1, 8'h01, 1'b0);
    idle(9);
    tick(1'b1, 8'h80, 1'b0);
    idle(9);
    tick(1'b1, 8'h55, 1'b0);
    idle(75);
    check_eq("b2b_frames", comp_seen - base, 2);

    // reset mid-frame with a held byte
    base = comp_seen;
    cyc  = 0;
    tick(1'b1, 8'hC3, 1'b0);
    idle(9);
    tick(1'b1, 8'h3C, 1'b0);
    idle(9);
    tick(1'b1, 8'hFF, 1'b1);
    idle(60);
    check_eq("reset_frames", comp_seen - base, 0);

    // random offers, bytes and occasional resets
    for (int i = 0; i < 800; i++)
      tick(($urandom_range(0, 5) == 0), 8'($urandom), ($urandom_range(0, 399) == 0));
    idle(2 * FRAME + 4);

    // default baud rate
    reset_s = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("slow_ready", tx_ready_s, 1'b1);
    check_eq("slow_idle", tx_serial_s, 1'b1);
    tx_valid_s = 1'b1;
    tx_byte_s  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    tx_valid_s = 1'b0;
    tx_byte_s  = 8'hFF;
    first_low = -1; last_low = -1; low_cnt = 0; comp_n = -1; comp_cnt = 0;
    for (int n = 1; n <= 52100; n++) begin
      if (tx_serial_s === 1'b0) begin
        if (first_low < 0) first_low = n;
        last_low = n;
        low_cnt++;
      end
      if (complete_s === 1'b1) begin
        comp_n = n;
        comp_cnt++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("slow_first_low", first_low, 1);
    check_eq("slow_low_cnt", low_cnt, 46872);
    check_eq("slow_last_low", last_low, 46872);
    check_eq("slow_comp_cnt", comp_cnt, 1);
    check_eq("slow_comp_delay", comp_n - first_low, 52080);
    check_eq("slow_end_idle", tx_serial_s, 1'b1);
    check_eq("slow_end_active", tx_active_s, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
